// File: rtl/student_tlul_socket_1n.sv
// TL-UL type package and a 1-to-N address-decoding socket with in-order response
// tracking and an internal error responder for unmapped addresses.
package tlul_pkg;
  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  // Entry i sits at i*0x100; sliced down to NUM entries by the socket.
  localparam logic [15:0][31:0] DEFAULT_DEV_BASE = {
    32'h0F00, 32'h0E00, 32'h0D00, 32'h0C00, 32'h0B00, 32'h0A00, 32'h0900, 32'h0800,
    32'h0700, 32'h0600, 32'h0500, 32'h0400, 32'h0300, 32'h0200, 32'h0100, 32'h0000
  };
endpackage

module student_tlul_socket_1n
  import tlul_pkg::*;
#(
  parameter int unsigned NUM = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [NUM-1:0][31:0] DEV_BASE = DEFAULT_DEV_BASE[NUM-1:0],
  parameter logic [NUM-1:0][31:0] DEV_MASK = {NUM{32'hFFFF_FF00}}
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  tl_h2d_t             tl_host_i,
  output tl_d2h_t             tl_host_o,
  output tl_h2d_t [NUM-1:0]   tl_device_o,
  input  tl_d2h_t [NUM-1:0]   tl_device_i,
  output logic                busy_o,
  output logic [15:0]         err_cnt_o
);
  localparam int unsigned SW = $clog2(NUM + 1);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [SW-1:0] ERR = SW'(NUM);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  logic [CW-1:0] cnt_reg;
  logic [SW-1:0] target_reg;
  logic [0:0]    resp_state_reg;
  logic [2:0]    resp_opcode_reg;
  logic [1:0]    resp_size_reg;
  logic [7:0]    resp_source_reg;
  logic [15:0]   err_cnt_reg;

  logic [NUM-1:0]    hit;
  logic [SW-1:0]     sel;
  logic              ok;
  logic              a_hs;
  logic              d_hs;
  logic              cnt_nz;
  logic [NUM:0]      slot_a_ready;
  tl_d2h_t [NUM:0]   slot_rsp;

  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_slot
      assign hit[gi]          = (tl_host_i.a_address & DEV_MASK[gi]) == DEV_BASE[gi];
      assign slot_a_ready[gi] = tl_device_i[gi].a_ready;
      assign slot_rsp[gi]     = tl_device_i[gi];
    end
  endgenerate

  // Slot NUM is the error responder, so host-side muxing needs no special case.
  assign slot_a_ready[NUM] = (resp_state_reg == ST_IDLE);
  always_comb begin
    slot_rsp[NUM]          = '0;
    slot_rsp[NUM].d_valid  = (resp_state_reg == ST_RESP);
    slot_rsp[NUM].d_opcode = (resp_opcode_reg == Get) ? AccessAckData : AccessAck;
    slot_rsp[NUM].d_size   = resp_size_reg;
    slot_rsp[NUM].d_source = resp_source_reg;
    slot_rsp[NUM].d_error  = 1'b1;
  end

  // Lowest index wins when windows overlap.
  always_comb begin
    sel = ERR;
    for (int i = int'(NUM) - 1; i >= 0; i--) begin
      if (hit[i]) sel = SW'(i);
    end
  end

  assign cnt_nz = (cnt_reg != '0);
  // Only one target may be in flight, which keeps responses ordered without a buffer.
  assign ok     = (cnt_reg < CW'(MAX_OUTSTANDING)) && (!cnt_nz || sel == target_reg);

  always_comb begin
    for (int i = 0; i < int'(NUM); i++) begin
      tl_device_o[i]         = tl_host_i;
      tl_device_o[i].a_valid = tl_host_i.a_valid & ok & (sel == SW'(i));
      tl_device_o[i].d_ready = tl_host_i.d_ready & (target_reg == SW'(i)) & cnt_nz;
    end
  end

  always_comb begin
    tl_host_o         = slot_rsp[target_reg];
    tl_host_o.d_valid = slot_rsp[target_reg].d_valid & cnt_nz;
    tl_host_o.a_ready = ok & slot_a_ready[sel];
  end

  assign a_hs      = tl_host_i.a_valid & tl_host_o.a_ready;
  assign d_hs      = tl_host_o.d_valid & tl_host_i.d_ready;
  assign busy_o    = cnt_nz;
  assign err_cnt_o = err_cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg    <= '0;
      target_reg <= '0;
    end else begin
      if (a_hs && !d_hs) cnt_reg <= cnt_reg + CW'(1);
      else if (!a_hs && d_hs) cnt_reg <= cnt_reg - CW'(1);
      if (a_hs) target_reg <= sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_state_reg  <= ST_IDLE;
      resp_opcode_reg <= '0;
      resp_size_reg   <= '0;
      resp_source_reg <= '0;
      err_cnt_reg     <= '0;
    end else if (resp_state_reg == ST_IDLE) begin
      if (a_hs && sel == ERR) begin
        resp_state_reg  <= ST_RESP;
        resp_opcode_reg <= tl_host_i.a_opcode;
        resp_size_reg   <= tl_host_i.a_size;
        resp_source_reg <= tl_host_i.a_source;
        if (err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 16'd1;
      end
    end else if (d_hs && target_reg == ERR) begin
      resp_state_reg <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_student_tlul_socket_1n.sv
// Randomised and directed bench for the TL-UL 1-to-N socket, scoreboard-checked
// against an address-range model of the device map.
module tb_student_tlul_socket_1n;
  import tlul_pkg::*;

  localparam int NUM  = 4;
  localparam int MAXO = 4;
  // Device 3 covers 0x000-0xFFF and overlaps devices 0..2, which must win.
  localparam logic [NUM-1:0][31:0] BASE = {32'h0000, 32'h0200, 32'h0100, 32'h0000};
  localparam logic [NUM-1:0][31:0] MASK = {32'hFFFF_F000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00};

  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
  } req_t;

  logic clk;
  logic rst_n;
  tl_h2d_t host_a;
  logic host_d_ready;
  tl_h2d_t host_h2d;
  tl_d2h_t host_d2h;
  tl_h2d_t [NUM-1:0] dev_h2d;
  tl_d2h_t [NUM-1:0] dev_d2h;
  logic busy;
  logic [15:0] err_cnt;

  int n_tests = 0;
  int n_fail = 0;
  int ar_pct, dv_pct, dr_mode;
  logic spur_en;
  exp_t sb_q[$];
  logic [15:0] err_model;
  req_t dq[NUM][$];
  logic dv[NUM];

  student_tlul_socket_1n #(
    .NUM(NUM), .MAX_OUTSTANDING(MAXO), .DEV_BASE(BASE), .DEV_MASK(MASK)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .tl_host_i(host_h2d), .tl_host_o(host_d2h),
    .tl_device_o(dev_h2d), .tl_device_i(dev_d2h), .busy_o(busy), .err_cnt_o(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    host_h2d         = host_a;
    host_h2d.d_ready = host_d_ready;
  end

  // Device map as plain address ranges; anything else is unmapped.
  function automatic int ref_dev(input logic [31:0] a);
    if (a < 32'h100) return 0;
    if (a < 32'h200) return 1;
    if (a < 32'h300) return 2;
    if (a < 32'h1000) return 3;
    return NUM;
  endfunction

  function automatic logic [31:0] dev_data(input int d, input logic [31:0] a);
    logic [3:0] dn;
    dn = 4'(d);
    return {dn, 4'hC, a[23:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Device models: accept with random a_ready, answer in order with random delay.
  initial begin
    req_t r;
    dev_d2h = '0;
    for (int i = 0; i < NUM; i++) dv[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM; i++) begin
        if (rst_n !== 1'b1) begin
          dq[i].delete();
          dv[i] = 1'b0;
        end else begin
          if (dev_h2d[i].a_valid && dev_d2h[i].a_ready) begin
            r.addr = dev_h2d[i].a_address;
            r.op   = dev_h2d[i].a_opcode;
            r.size = dev_h2d[i].a_size;
            r.src  = dev_h2d[i].a_source;
            dq[i].push_back(r);
          end
          if (dv[i] && dev_h2d[i].d_ready) begin
            r = dq[i].pop_front();
            dv[i] = 1'b0;
          end
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM; i++) begin
        dev_d2h[i] = '0;
        dev_d2h[i].a_ready = ($urandom_range(99) < ar_pct);
        if (rst_n === 1'b1 && !dv[i] && dq[i].size() != 0 && $urandom_range(99) < dv_pct)
          dv[i] = 1'b1;
        if (dv[i]) begin
          r = dq[i][0];
          dev_d2h[i].d_valid  = 1'b1;
          dev_d2h[i].d_opcode = (r.op == Get) ? AccessAckData : AccessAck;
          dev_d2h[i].d_size   = r.size;
          dev_d2h[i].d_source = r.src;
          dev_d2h[i].d_data   = (r.op == Get) ? dev_data(i, r.addr) : 32'h0;
        end
        if (spur_en && i == 1) begin
          dev_d2h[i].d_valid  = 1'b1;
          dev_d2h[i].d_opcode = AccessAckData;
          dev_d2h[i].d_data   = 32'hDEAD_BEEF;
        end
      end
    end
  end

  initial begin
    host_d_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (dr_mode == 2) host_d_ready = 1'($urandom_range(1));
      else host_d_ready = (dr_mode == 1);
    end
  end

  // Monitor: occupancy, A-side routing and in-order D responses.
  logic [NUM-1:0] av;
  logic [NUM-1:0] exp_av;
  int md;
  exp_t me;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      sb_q.delete();
      err_model = '0;
    end else begin
      chk("busy_vs_outstanding", 64'(busy), 64'(sb_q.size() != 0));
      if (host_h2d.a_valid && host_d2h.a_ready) begin
        md = ref_dev(host_h2d.a_address);
        for (int i = 0; i < NUM; i++) begin
          av[i]     = dev_h2d[i].a_valid;
          exp_av[i] = (md == i);
        end
        chk("a_route", 64'(av), 64'(exp_av));
        me.op   = (host_h2d.a_opcode == Get) ? AccessAckData : AccessAck;
        me.size = host_h2d.a_size;
        me.src  = host_h2d.a_source;
        me.data = (md < NUM && host_h2d.a_opcode == Get) ? dev_data(md, host_h2d.a_address) : 32'h0;
        me.err  = (md == NUM);
        sb_q.push_back(me);
        if (md == NUM && err_model != 16'hFFFF) err_model = err_model + 16'd1;
      end
      if (host_d2h.d_valid && host_h2d.d_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_d", 64'(1), 64'(0));
        end else begin
          me = sb_q.pop_front();
          chk("d_resp", 64'({host_d2h.d_opcode, host_d2h.d_size, host_d2h.d_source,
                             host_d2h.d_data, host_d2h.d_error}), 64'(me));
          $display("[TB] rsp src=%0h op=%0h data=%08h err=%0b", host_d2h.d_source,
                   host_d2h.d_opcode, host_d2h.d_data, host_d2h.d_error);
        end
      end
    end
  end

  task automatic drive_a(input logic [31:0] addr, input logic [2:0] op,
                         input logic [1:0] size, input logic [7:0] src);
    host_a.a_valid   = 1'b1;
    host_a.a_opcode  = op;
    host_a.a_param   = '0;
    host_a.a_size    = size;
    host_a.a_source  = src;
    host_a.a_address = addr;
    host_a.a_mask    = 4'hF;
    host_a.a_data    = $urandom();
  endtask

  task automatic wait_accept(input string name);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (host_d2h.a_ready) got = 1'b1;
    end
    if (!got) chk(name, 64'(0), 64'(1));
    @(posedge clk);
    #1;
    host_a.a_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) chk(name, 64'(0), 64'(1));
  endtask

  initial begin
    logic got;
    logic [31:0] addr;
    logic [2:0] op;
    int k;
    rst_n = 1'b0;
    host_a = '0;
    ar_pct = 100;
    dv_pct = 100;
    dr_mode = 1;
    spur_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NUM; i++) av[i] = dev_h2d[i].a_valid;
    chk("rst_d_valid", 64'(host_d2h.d_valid), 64'(0));
    chk("rst_a_valid", 64'(av), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err_cnt", 64'(err_cnt), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Get to device 1.
    drive_a(32'h0000_0104, Get, 2'd2, 8'd1);
    wait_accept("t1_accept");
    chk("t1_busy_after_accept", 64'(busy), 64'(1));
    wait_drain("t1_drain");

    // Put to an unmapped address.
    drive_a(32'h0001_0000, PutFullData, 2'd2, 8'd3);
    wait_accept("t2_accept");
    chk("t2_err_d_valid_next", 64'(host_d2h.d_valid), 64'(1));
    chk("t2_err_cnt", 64'(err_cnt), 64'(1));
    wait_drain("t2_drain");

    // Fill to MAX_OUTSTANDING with d_ready low, then drain.
    dr_mode = 0;
    for (int i = 0; i < MAXO; i++) begin
      drive_a(32'h200 + 32'(i * 4), Get, 2'd2, 8'(20 + i));
      wait_accept("t3_fill_accept");
    end
    drive_a(32'h210, Get, 2'd2, 8'd24);
    repeat (3) @(negedge clk);
    chk("t3_stall_at_max", 64'(host_d2h.a_ready), 64'(0));
    chk("t3_stall_no_fwd", 64'(dev_h2d[2].a_valid), 64'(0));
    dr_mode = 1;
    wait_accept("t3_fifth_accept");
    wait_drain("t3_drain");

    // A second target waits until the first drains.
    dv_pct = 0;
    drive_a(32'h000, Get, 2'd2, 8'd30);
    wait_accept("t4_first_accept");
    drive_a(32'h400, Get, 2'd2, 8'd31);
    repeat (3) @(negedge clk);
    chk("t4_other_target_stall", 64'(host_d2h.a_ready), 64'(0));
    chk("t4_other_target_no_fwd", 64'(dev_h2d[3].a_valid), 64'(0));
    dv_pct = 100;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (host_d2h.a_ready) begin
        got = 1'b1;
        chk("t4_fwd_when_idle", 64'(busy), 64'(0));
        chk("t4_fwd_route", 64'(dev_h2d[3].a_valid), 64'(1));
      end
    end
    if (!got) chk("t4_second_accept", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    host_a.a_valid = 1'b0;
    wait_drain("t4_drain");

    // Spurious response from a non-target device, then simultaneous A and D.
    dv_pct = 0;
    drive_a(32'h000, Get, 2'd2, 8'd40);
    wait_accept("t5_a0");
    drive_a(32'h004, Get, 2'd2, 8'd41);
    wait_accept("t5_a1");
    spur_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_spur_blocked", 64'(host_d2h.d_valid), 64'(0));
    chk("t5_spur_no_ready", 64'(dev_h2d[1].d_ready), 64'(0));
    spur_en = 1'b0;
    dv_pct = 100;
    @(posedge clk);
    #1;
    drive_a(32'h008, Get, 2'd2, 8'd42);
    wait_accept("t5_a2");
    chk("t5_busy_after_ad", 64'(busy), 64'(1));
    wait_drain("t5_drain");

    // Reset while the error responder holds a response.
    dr_mode = 0;
    drive_a(32'h0001_0000, PutPartialData, 2'd1, 8'd5);
    wait_accept("t6_accept");
    chk("t6_resp_pending", 64'(host_d2h.d_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_d_valid", 64'(host_d2h.d_valid), 64'(0));
    chk("t6_rst_busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dr_mode = 1;
    @(posedge clk);
    #1;
    chk("t6_err_cnt_after_rst", 64'(err_cnt), 64'(0));

    // Randomised traffic.
    ar_pct = 70;
    dv_pct = 50;
    dr_mode = 2;
    for (int t = 0; t < 300; t++) begin
      repeat ($urandom_range(2)) begin
        @(posedge clk);
        #1;
      end
      k = $urandom_range(4);
      case (k)
        0, 1, 2: addr = 32'(k) * 32'h100 + {22'h0, 8'($urandom_range(63)), 2'b00};
        3:       addr = 32'h300 + {20'h0, 10'($urandom_range(831)), 2'b00};
        default: addr = $urandom() | 32'h0001_0000;
      endcase
      case ($urandom_range(2))
        0:       op = Get;
        1:       op = PutFullData;
        default: op = PutPartialData;
      endcase
      drive_a(addr, op, (op == Get) ? 2'd2 : 2'($urandom_range(2)), 8'($urandom_range(255)));
      wait_accept("rand_accept");
    end
    wait_drain("rand_drain");
    chk("final_err_cnt", 64'(err_cnt), 64'(err_model));
    chk("final_sb_empty", 64'(sb_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
